// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the CNN inference datapath (conv/pool/flatten/fc).
//   - default data width / fractional bits used by every stage
//   - fc_layer controller state encoding
//   - clog2: ceil(log2(value)), never below 1 so it is safe as a port width
//   - sat_n: clamp a wide signed value into the signed n-bit range; the
//     result stays 64 bits wide and the caller size-casts it down to n bits
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int CNN_N    = 16;
   localparam int CNN_FRAC = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_FINISH = 2'd2
   } fc_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      if (r < 1) r = 1;
      return r;
   endfunction

   function automatic logic signed [63:0] sat_n(input logic signed [63:0] v,
                                                input int n);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (n - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// ---------------------------------------------------------------------------
// fc_mac_lane
//   One output neuron of the dense layer: accumulates data*weight products
//   and presents the rescaled, biased and saturated score combinationally.
// Ports
//   clk, reset_n   clock / async active-low reset
//   clear          zero the accumulator (wins over enable)
//   enable         add data*weight to the accumulator this cycle
//   data, weight   signed N-bit operands
//   bias           signed N-bit bias, same Q format as the data
//   score          saturate((acc >>> FRAC) + bias), signed N bits
// ---------------------------------------------------------------------------
module fc_mac_lane
   import cnn_pkg::*;
#(
   parameter int N     = CNN_N,
   parameter int FRAC  = CNN_FRAC,
   parameter int ACC_W = 2 * CNN_N + 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         enable,
   input  logic [N-1:0] data,
   input  logic [N-1:0] weight,
   input  logic [N-1:0] bias,
   output logic [N-1:0] score
);

   logic signed [2*N-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W:0]   sum;

   assign prod     = $signed(data) * $signed(weight);
   assign prod_ext = $signed({{(ACC_W - 2*N){prod[2*N-1]}}, prod});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    acc_reg <= '0;
      else if (clear)  acc_reg <= '0;
      else if (enable) acc_reg <= acc_reg + prod_ext;
   end

   // Arithmetic shift floors toward -inf; one extra bit keeps the bias add exact.
   assign shifted = acc_reg >>> FRAC;
   assign sum     = $signed({shifted[ACC_W-1], shifted})
                  + $signed({{(ACC_W + 1 - N){bias[N-1]}}, bias});
   assign score   = N'(sat_n(64'(sum), N));

endmodule

// File: rtl/fc_layer.sv
// ---------------------------------------------------------------------------
// fc_layer
//   Dense classifier stage: consumes IN_LEN features one per beat, computes
//   OUT_LEN biased dot products in parallel lanes, registers the saturated
//   scores and the argmax class.
// Ports
//   clk, reset_n   clock / async active-low reset
//   start          begin (or restart) an inference; aborts any run in flight
//   in_valid       in_data carries the next feature this cycle
//   in_data        signed feature, Q(N-FRAC).FRAC
//   weights_flat   W[j][i] at [(j*IN_LEN+i)*N +: N], stable start..done
//   bias_flat      B[j] at [j*N +: N], stable start..done
//   out_flat       registered score j at [j*N +: N]
//   class_out      index of the highest score, lowest index on ties
//   busy           high from start until done
//   done           one-cycle pulse when out_flat/class_out are updated
// ---------------------------------------------------------------------------
module fc_layer
   import cnn_pkg::*;
#(
   parameter int N       = CNN_N,
   parameter int FRAC    = CNN_FRAC,
   parameter int IN_LEN  = 16,
   parameter int OUT_LEN = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [N-1:0]                  in_data,
   input  logic [N*IN_LEN*OUT_LEN-1:0]   weights_flat,
   input  logic [N*OUT_LEN-1:0]          bias_flat,
   output logic [N*OUT_LEN-1:0]          out_flat,
   output logic [clog2(OUT_LEN)-1:0]     class_out,
   output logic                          busy,
   output logic                          done
);

   localparam int IDX_W = clog2(IN_LEN);
   localparam int CLS_W = clog2(OUT_LEN);
   // One guard bit per doubling of IN_LEN keeps the sum of products exact.
   localparam int ACC_W = 2 * N + IDX_W;

   fc_state_t        state_reg, state_next;
   logic [IDX_W-1:0] idx_reg;
   logic             accept;
   logic             last_beat;

   logic [N-1:0]     score [OUT_LEN];
   logic [CLS_W-1:0] best_idx;
   logic [N-1:0]     best_val;

   logic [N*OUT_LEN-1:0] out_flat_reg;
   logic [CLS_W-1:0]     class_reg;
   logic                 busy_reg;
   logic                 done_reg;

   // A beat coinciding with start belongs to the aborted run and is dropped.
   assign accept    = (state_reg == ST_ACCUM) && in_valid && !start;
   assign last_beat = accept && (idx_reg == IDX_W'(IN_LEN - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (start) begin
         state_next = ST_ACCUM;
      end else begin
         case (state_reg)
            ST_ACCUM:  if (last_beat) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       idx_reg <= '0;
      else if (start)     idx_reg <= '0;
      else if (last_beat) idx_reg <= '0;
      else if (accept)    idx_reg <= idx_reg + 1'b1;
   end

   genvar gi, gk;
   generate
      for (gi = 0; gi < OUT_LEN; gi = gi + 1) begin : g_lane
         logic [N-1:0] w_row [IN_LEN];
         logic [N-1:0] lane_w;

         for (gk = 0; gk < IN_LEN; gk = gk + 1) begin : g_w
            assign w_row[gk] = weights_flat[(gi*IN_LEN + gk)*N +: N];
         end
         assign lane_w = w_row[idx_reg];

         fc_mac_lane #(
            .N     (N),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
         ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (start),
            .enable  (accept),
            .data    (in_data),
            .weight  (lane_w),
            .bias    (bias_flat[gi*N +: N]),
            .score   (score[gi])
         );
      end
   endgenerate

   // Strict greater-than keeps the earliest index on ties.
   always_comb begin
      best_idx = '0;
      best_val = score[0];
      for (int j = 1; j < OUT_LEN; j++) begin
         if ($signed(score[j]) > $signed(best_val)) begin
            best_idx = CLS_W'(j);
            best_val = score[j];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_flat_reg <= '0;
         class_reg    <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else if (start) begin
         busy_reg <= 1'b1;
         done_reg <= 1'b0;
      end else if (state_reg == ST_FINISH) begin
         for (int j = 0; j < OUT_LEN; j++) out_flat_reg[j*N +: N] <= score[j];
         class_reg <= best_idx;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b1;
      end else begin
         done_reg <= 1'b0;
      end
   end

   assign out_flat  = out_flat_reg;
   assign class_out = class_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;

endmodule
